muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative 64-bit signed multiply/divide unit sitting beside the ALU in the multicycle datapath.
//  Consumes operands from register A/B outputs; its result feeds the write-back mux (WriteDataReg path).
//  Controle launches it with a start pulse, then holds its state until done, so one op is in flight.
// PARAMETERS
//  XLEN  64  operand/result width; counter width is $clog2(XLEN)+1
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     reset, asynchronous, active-low
//  start     in   1     launch op; sampled only in IDLE
//  op        in   2     00 MUL lo, 01 MULH hi (signed x signed), 10 DIV signed, 11 REM signed
//  src_a     in   XLEN  multiplicand / dividend (RegA)
//  src_b     in   XLEN  multiplier / divisor (RegB)
//  busy      out  1     high from the first edge after an accepted start until done
//  done      out  1     one-cycle pulse; result is valid that cycle and is held afterwards
//  result    out  XLEN  selected product half / quotient / remainder
//  div_zero  out  1     divide-by-zero flag, valid with done (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE. busy=0, done=0, result=0, div_zero=0. Counters and accumulators are cleared.
//  FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start=1 latches op, |src_a|, |src_b| and the sign bits, sets cnt=XLEN, and moves to CALC.
//   CALC: one radix-2 step per cycle, cnt--. Leave when cnt reaches 0 (XLEN cycles).
//     MUL/MULH: shift-add on a 2*XLEN product register using unsigned magnitudes.
//     DIV/REM: restoring division; partial remainder is XLEN+1 bits, quotient shifts in from the LSB.
//   FIX: apply sign correction.
//     Product is negated when sign_a^sign_b.
//     Quotient is negated when sign_a^sign_b; remainder takes the sign of the dividend.
//   DONE: result is registered, done=1 for exactly 1 cycle, then return to IDLE.
//  Latency: start sampled at edge T; done is high in the cycle after edge T+XLEN+2 (66 clocks at XLEN=64).
//  Shortcuts (IDLE -> DONE directly; done in the cycle after edge T+1):
//   divisor==0: DIV result = all ones; REM result = src_a.
//   src_a==-2^(XLEN-1) and src_b==-1: DIV result = -2^(XLEN-1); REM result = 0.
//  Magnitude of -2^(XLEN-1) is handled as unsigned 2^(XLEN-1); no overflow inside CALC.
//  start while busy or in DONE: ignored, no queuing.
//  Operands are not re-sampled after the start edge; src_a/src_b may change freely during CALC.
//  result keeps its last value until the next DONE. The registered result changes only in DONE.
//  rst asserted mid-op: the op is aborted immediately and all outputs return to reset values.
// CONFIGURATION
//  MULDIV_DIVZERO_EXC_EN defined:
//   div_zero=1 in the done cycle of a DIV/REM with divisor 0; the result values above are unchanged.
//   Controle uses this flag to take the exception path.
//  Not defined: div_zero is tied 0. Divide by zero silently returns the RISC-V default results.
// STRUCTURE
//  muldiv_pkg holds:
//   typedef enum logic[1:0] muldiv_op_t {OP_MUL, OP_MULH, OP_DIV, OP_REM}
//   typedef enum muldiv_state_t {S_IDLE, S_CALC, S_FIX, S_DONE}
//   localparam XLEN_DEF=64
//  One sub-module, muldiv_negate: combinational conditional two's-complement (in, neg -> out).
//   It is used for the operand magnitudes and for the sign fix.
// TESTING
//  1. MUL 7 x -3 -> done at +66 clocks, result = -21 (0xFFFF_FFFF_FFFF_FFEB), busy high for 65 cycles.
//  2. MULH 0x8000_0000_0000_0000 x 2 -> result = 0xFFFF_FFFF_FFFF_FFFF. MUL of same -> 0.
//  3. DIV -7 / 2 -> result = -3. REM -7 / 2 -> result = -1. REM 7 / -2 -> result = 1.
//  4. DIV 5 / 0 -> result = all ones, done after 1 clock, div_zero=1 (macro on) / 0 (macro off).
//     REM 5 / 0 -> result = 5.
//  5. DIV 0x8000_0000_0000_0000 / -1 -> result = 0x8000_0000_0000_0000. REM -> 0. Shortcut latency.
//  6. Second start during CALC is ignored (one done only). rst low at cycle 30 -> busy=0, result=0.
//     A following op completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states, default width.
package muldiv_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: out = neg ? -in : in. Purely combinational, no backpressure.
module muldiv_negate #(
  parameter int W = 64
) (
  input  logic [W-1:0] in,
  input  logic         neg,
  output logic [W-1:0] out
);

  assign out = neg ? (~in + {{(W-1){1'b0}}, 1'b1}) : in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed MUL/MULH/DIV/REM, XLEN+2 cycles to done (1 for div shortcuts); start ignored unless idle.
// MULDIV_DIVZERO_EXC_EN enables the div_zero flag; otherwise div_zero is tied low.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state, state_nxt;
  muldiv_op_t      op_in, op_q;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]   rem;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] fix_val;

  assign op_in = muldiv_op_t'(op);

  muldiv_negate #(.W(XLEN)) u_neg_a (.in(src_a), .neg(src_a[XLEN-1]), .out(mag_a_in));
  muldiv_negate #(.W(XLEN)) u_neg_b (.in(src_b), .neg(src_b[XLEN-1]), .out(mag_b_in));

  // Divide shortcuts bypass CALC/FIX entirely.
  logic            is_div_in, b_zero, ovf, shortcut;
  logic [XLEN-1:0] short_val;

  assign is_div_in = (op_in == OP_DIV) || (op_in == OP_REM);
  assign b_zero    = (src_b == '0);
  assign ovf       = (src_a == MIN_VAL) && (src_b == '1);
  assign shortcut  = is_div_in && (b_zero || ovf);

  always_comb begin
    short_val = '0;
    if (op_in == OP_DIV) short_val = b_zero ? '1 : MIN_VAL;
    else                 short_val = b_zero ? src_a : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = shortcut ? S_DONE : S_CALC;
      S_CALC:  if (cnt == CW'(1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_ok;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
  assign div_shift = {rem[XLEN-1:0], acc[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
  assign div_ok    = ~div_diff[XLEN+1];

  logic [2*XLEN-1:0] fix_in, fix_out;
  logic              fix_neg;
  logic [XLEN-1:0]   fix_sel;

  always_comb begin
    fix_in  = acc;
    fix_neg = sign_a ^ sign_b;
    case (op_q)
      OP_DIV: fix_in = {{XLEN{1'b0}}, acc[XLEN-1:0]};
      OP_REM: begin
        fix_in  = {{(XLEN-1){1'b0}}, rem};
        fix_neg = sign_a;
      end
      default: ;
    endcase
  end

  muldiv_negate #(.W(2*XLEN)) u_neg_fix (.in(fix_in), .neg(fix_neg), .out(fix_out));

  assign fix_sel = (op_q == OP_MULH) ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      op_q    <= OP_MUL;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      rem     <= '0;
      cnt     <= '0;
      fix_val <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state == S_CALC) || (state == S_FIX);
      done  <= (state == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          op_q    <= op_in;
          sign_a  <= src_a[XLEN-1];
          sign_b  <= src_b[XLEN-1];
          mag_a   <= mag_a_in;
          mag_b   <= mag_b_in;
          cnt     <= CW'(XLEN);
          rem     <= '0;
          acc     <= is_div_in ? {{XLEN{1'b0}}, mag_a_in} : {{XLEN{1'b0}}, mag_b_in};
          fix_val <= short_val;
        end
        S_CALC: begin
          cnt <= cnt - CW'(1);
          if (op_q == OP_DIV || op_q == OP_REM) begin
            if (div_ok) begin
              rem             <= div_diff[XLEN:0];
              acc[XLEN-1:0]   <= {acc[XLEN-2:0], 1'b1};
            end else begin
              rem             <= div_shift;
              acc[XLEN-1:0]   <= {acc[XLEN-2:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
        end
        S_FIX:  fix_val <= fix_sel;
        S_DONE: result  <= fix_val;
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIVZERO_EXC_EN
  logic dz_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dz_q     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (state == S_IDLE && start) dz_q <= is_div_in && b_zero;
      if (state == S_DONE)          div_zero <= dz_q;
      else                          div_zero <= 1'b0;
    end
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int XLEN = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef MULDIV_DIVZERO_EXC_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [63:0] src_a, src_b;
  logic        busy, done, div_zero;
  logic [63:0] result;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .result(result), .div_zero(div_zero)
  );

  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ea, eb, p;
    longint sa, sb;
    ea = {{64{a[63]}}, a};
    eb = {{64{b[63]}}, b};
    p  = ea * eb;
    sa = a;
    sb = b;
    case (o)
      2'd0: return p[63:0];
      2'd1: return p[127:64];
      2'd2: begin
        if (b == 64'd0) return ONES;
        if (a == MIN64 && b == ONES) return MIN64;
        return 64'(sa / sb);
      end
      default: begin
        if (b == 64'd0) return a;
        if (a == MIN64 && b == ONES) return 64'd0;
        return 64'(sa % sb);
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    if (o[1] && (b == 64'd0 || (a == MIN64 && b == ONES))) return 1;
    return XLEN + 2;
  endfunction

  function automatic logic ref_dz(input logic [1:0] o, input logic [63:0] b);
    return DZ_EN && o[1] && (b == 64'd0);
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 64'($signed($urandom_range(0, 40)) - 20);
      1: return MIN64;
      2: return ONES;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Launch one op, scramble the inputs afterwards, and wait (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output logic dz, output int lat, output int bcnt);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); src_a = {$urandom, $urandom}; src_b = {$urandom, $urandom};
    lat = -1; bcnt = 0; res = '0; dz = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k; res = result; dz = div_zero;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, div_zero} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, div_zero}); else passes++;
    checks++; if (result !== 64'd0) $display("FAIL reset_result got %h want 0", result); else passes++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mul;
    logic [1:0]  t_op [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic [63:0] t_a  [4] = '{64'd7, MIN64, MIN64, ONES};
    logic [63:0] t_b  [4] = '{ONES - 64'd2, 64'd2, 64'd2, ONES};
    logic [63:0] t_e  [4] = '{64'hFFFF_FFFF_FFFF_FFEB, ONES, 64'd0, 64'd0};
    logic [1:0] o; logic [63:0] a, b, e, res; logic dz; int lat, bc;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin o = t_op[i]; a = t_a[i]; b = t_b[i]; e = t_e[i]; end
      else begin o = 2'($urandom_range(0, 1)); a = rnd_operand(); b = rnd_operand(); e = ref_res(o, a, b); end
      run_op(o, a, b, res, dz, lat, bc);
      checks++; if (lat !== XLEN + 2) $display("FAIL mul[%0d] latency got %0d want %0d", i, lat, XLEN + 2); else passes++;
      checks++; if (bc !== XLEN + 1) $display("FAIL mul[%0d] busy_cycles got %0d want %0d", i, bc, XLEN + 1); else passes++;
      checks++; if (res !== e) $display("FAIL mul[%0d] op=%0d a=%h b=%h result got %h want %h", i, o, a, b, res, e); else passes++;
    end
  endtask

  task automatic test_div;
    logic [1:0]  t_op [4] = '{2'd2, 2'd3, 2'd3, 2'd2};
    logic [63:0] t_a  [4] = '{ONES - 64'd6, ONES - 64'd6, 64'd7, 64'd100};
    logic [63:0] t_b  [4] = '{64'd2, 64'd2, ONES - 64'd1, 64'd7};
    logic [63:0] t_e  [4] = '{ONES - 64'd2, ONES, 64'd1, 64'd14};
    logic [1:0] o; logic [63:0] a, b, e, res; logic dz; int lat, bc;
    for (int i = 0; i < 14; i++) begin
      if (i < 4) begin o = t_op[i]; a = t_a[i]; b = t_b[i]; e = t_e[i]; end
      else begin
        o = 2'($urandom_range(2, 3)); a = rnd_operand(); b = rnd_operand();
        e = ref_res(o, a, b);
      end
      run_op(o, a, b, res, dz, lat, bc);
      checks++; if (lat !== ref_lat(o, a, b)) $display("FAIL div[%0d] latency got %0d want %0d", i, lat, ref_lat(o, a, b)); else passes++;
      checks++; if (res !== e) $display("FAIL div[%0d] op=%0d a=%h b=%h result got %h want %h", i, o, a, b, res, e); else passes++;
      checks++; if (dz !== ref_dz(o, b)) $display("FAIL div[%0d] div_zero got %b want %b", i, dz, ref_dz(o, b)); else passes++;
    end
  endtask

  task automatic test_div_special;
    logic [1:0]  t_op [5] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd3};
    logic [63:0] t_a  [5] = '{64'd5, 64'd5, MIN64, MIN64, ONES - 64'd8};
    logic [63:0] t_b  [5] = '{64'd0, 64'd0, ONES, ONES, 64'd0};
    logic [63:0] t_e  [5] = '{ONES, 64'd5, MIN64, 64'd0, ONES - 64'd8};
    logic [63:0] res; logic dz; int lat, bc;
    for (int i = 0; i < 5; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], res, dz, lat, bc);
      checks++; if (lat !== 1) $display("FAIL special[%0d] latency got %0d want 1", i, lat); else passes++;
      checks++; if (res !== t_e[i]) $display("FAIL special[%0d] result got %h want %h", i, res, t_e[i]); else passes++;
      checks++; if (dz !== ref_dz(t_op[i], t_b[i])) $display("FAIL special[%0d] div_zero got %b want %b", i, dz, ref_dz(t_op[i], t_b[i])); else passes++;
      checks++; if (bc !== 0) $display("FAIL special[%0d] busy_cycles got %0d want 0", i, bc); else passes++;
    end
  endtask

  task automatic test_ignore_start;
    int n; logic [63:0] r, e;
    e = ref_res(2'd0, 64'd123456789, 64'(-987654321));
    @(negedge clk);
    op = 2'd0; src_a = 64'd123456789; src_b = 64'(-987654321); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    op = 2'd2; src_a = 64'd99; src_b = 64'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; r = '0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (done) begin
        n++;
        if (n == 1) r = result;
      end
    end
    checks++; if (n !== 1) $display("FAIL ignore_start done_pulses got %0d want 1", n); else passes++;
    checks++; if (r !== e) $display("FAIL ignore_start result got %h want %h", r, e); else passes++;
  endtask

  task automatic test_reset_mid_op;
    logic [63:0] res; logic dz; int lat, bc;
    @(negedge clk);
    op = 2'd2; src_a = 64'(-1000); src_b = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({busy, done, div_zero} !== 3'b000) $display("FAIL mid_reset flags got %b want 000", {busy, done, div_zero}); else passes++;
    checks++; if (result !== 64'd0) $display("FAIL mid_reset result got %h want 0", result); else passes++;
    @(negedge clk);
    rst = 1'b1;
    run_op(2'd3, 64'(-1000), 64'd7, res, dz, lat, bc);
    checks++; if (lat !== XLEN + 2) $display("FAIL after_reset latency got %0d want %0d", lat, XLEN + 2); else passes++;
    checks++; if (res !== 64'(-6)) $display("FAIL after_reset result got %h want %h", res, 64'(-6)); else passes++;
  endtask

  task automatic test_back_to_back;
    logic [1:0] o; logic [63:0] a, b, e, res; logic dz; int lat, bc;
    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom); a = rnd_operand(); b = rnd_operand(); e = ref_res(o, a, b);
      run_op(o, a, b, res, dz, lat, bc);
      checks++; if (res !== e) $display("FAIL b2b[%0d] op=%0d result got %h want %h", i, o, res, e); else passes++;
      @(negedge clk);
      checks++; if (done !== 1'b0) $display("FAIL b2b[%0d] done_width got %b want 0", i, done); else passes++;
      checks++; if (result !== e) $display("FAIL b2b[%0d] result_hold got %h want %h", i, result, e); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_ignore_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
